// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader: FSM states and the
// byte geometry of the header and the payload words.
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam int HDR_BYTES      = 4;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/byte_packer.sv
// Big-endian byte-to-word assembler shared by the header and payload phases.
// word/word_complete are combinational so the caller sees the full word in the cycle the last byte arrives.
module byte_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        load,
  output logic [31:0] word,
  output logic        word_complete
);

  logic [1:0]  byte_cnt;
  logic [23:0] shift_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (clear) begin
      byte_cnt <= '0;
      shift_q  <= '0;
    end else if (load) begin
      shift_q  <= word[23:0];
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // The counter wraps naturally after the last byte, so no explicit clear between words.
  assign word          = {shift_q, byte_in};
  assign word_complete = load && (byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Writer side of the instruction store: parses a word-count header, then streams
// big-endian words into instruction memory while holding the CPU until the load completes.
module program_loader
  import loader_pkg::*;
#(
  parameter int CAPACITY   = 512,
  parameter int BUS_WIDTH  = 32,
  parameter int ADDR_WIDTH = $clog2(CAPACITY)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [7:0]            byte_in,
  input  logic                  byte_valid,
  output logic                  byte_ready,
  output logic [ADDR_WIDTH-1:0] write_addr,
  output logic [BUS_WIDTH-1:0]  data_in,
  output logic                  wr_en,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_hold
);

  state_t                 state_q, state_d;
  logic [BUS_WIDTH-1:0]   count_q;
  logic [ADDR_WIDTH:0]    word_idx;
  logic [BUS_WIDTH-1:0]   pack_word;
  logic                   pack_complete;
  logic                   accept;
  logic                   start_go;
  logic                   last_word;

  assign byte_ready = (state_q == HDR) || (state_q == DATA);
  // An abort drops the byte offered alongside it.
  assign accept     = byte_valid && byte_ready && !abort;
  assign start_go   = start && !byte_ready;
  assign last_word  = (BUS_WIDTH'(word_idx) == count_q - BUS_WIDTH'(1));

  byte_packer u_packer (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (start_go),
    .byte_in       (byte_in),
    .load          (accept),
    .word          (pack_word),
    .word_complete (pack_complete)
  );

  // NOTE: next-state defaults to the current state first so no path leaves state_d unassigned (no latch).
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) state_d = HDR;
      end
      HDR: begin
        if (abort) begin
          state_d = ERR;
        end else if (pack_complete) begin
          if (pack_word == '0)                          state_d = DONE;
          else if (pack_word > BUS_WIDTH'(CAPACITY))    state_d = ERR;
          else                                          state_d = DATA;
        end
      end
      DATA: begin
        if (abort)                          state_d = ERR;
        else if (pack_complete && last_word) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      count_q    <= '0;
      word_idx   <= '0;
      write_addr <= '0;
      data_in    <= '0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_hold   <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_en   <= 1'b0;

      if (start_go) word_idx <= '0;

      if (state_q == HDR && pack_complete) count_q <= pack_word;

      if (state_q == DATA && pack_complete) begin
        wr_en      <= 1'b1;
        data_in    <= pack_word;
        write_addr <= word_idx[ADDR_WIDTH-1:0];
        word_idx   <= word_idx + 1'b1;
      end

      // Status flags follow the state being entered so they line up with state_q.
      busy     <= (state_d == HDR) || (state_d == DATA);
      done     <= (state_d == DONE);
      error    <= (state_d == ERR);
      cpu_hold <= (state_d != DONE);
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Directed self-checking bench for program_loader: normal, boundary, abort and reset loads.
module tb_program_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [8:0]  write_addr;
  logic [31:0] data_in;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_hold;

  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  int last_addr = -1;
  logic [31:0] mem [0:511];

  always #5 clk = ~clk;

  program_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .write_addr (write_addr),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_hold   (cpu_hold)
  );

  // Memory model: captures every write pulse away from the clock edge.
  always @(negedge clk) begin
    if (wr_en) begin
      mem[write_addr] = data_in;
      last_addr       = int'(write_addr);
      wr_count        = wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[31:24]);
    send_byte(w[23:16]);
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  // Bounded wait for the load to leave HDR/DATA, plus one cycle so the last write is captured.
  task automatic wait_end(input int max_cycles);
    int n = 0;
    while (busy && n < max_cycles) begin
      tick();
      n++;
    end
    check("wait_timeout_busy", {31'b0, busy}, 32'd0);
    tick();
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;

    // Reset then idle
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check("rst_wr_en",      {31'b0, wr_en},      32'd0);
    check("rst_cpu_hold",   {31'b0, cpu_hold},   32'd1);
    check("rst_busy",       {31'b0, busy},       32'd0);
    check("rst_done",       {31'b0, done},       32'd0);
    check("rst_error",      {31'b0, error},      32'd0);
    check("rst_byte_ready", {31'b0, byte_ready}, 32'd0);
    byte_in    = 8'hFF;
    byte_valid = 1'b1;
    #1;
    check("idle_byte_ready", {31'b0, byte_ready}, 32'd0);
    tick();
    tick();
    byte_valid = 1'b0;
    check("idle_no_write", wr_count, 32'd0);

    // Two-word load, back-to-back bytes
    wr_count = 0;
    pulse_start();
    check("load2_busy",       {31'b0, busy},       32'd1);
    check("load2_byte_ready", {31'b0, byte_ready}, 32'd1);
    check("load2_hold",       {31'b0, cpu_hold},   32'd1);
    send_word(32'h0000_0002);
    send_word(32'h3C08_0005);
    send_word(32'h2109_0007);
    wait_end(20);
    check("load2_wr_count", wr_count, 32'd2);
    check("load2_mem0",     mem[0],   32'h3C08_0005);
    check("load2_mem1",     mem[1],   32'h2109_0007);
    check("load2_last",     last_addr, 32'd1);
    check("load2_done",     {31'b0, done},       32'd1);
    check("load2_busy_end", {31'b0, busy},       32'd0);
    check("load2_hold_end", {31'b0, cpu_hold},   32'd0);
    check("load2_ready_end",{31'b0, byte_ready}, 32'd0);

    // Oversize header (513)
    wr_count = 0;
    pulse_start();
    check("over_done_clr", {31'b0, done}, 32'd0);
    send_word(32'h0000_0201);
    wait_end(10);
    check("over_error",    {31'b0, error},    32'd1);
    check("over_done",     {31'b0, done},     32'd0);
    check("over_hold",     {31'b0, cpu_hold}, 32'd1);
    check("over_no_write", wr_count, 32'd0);

    // Full-capacity load (512 words)
    wr_count = 0;
    pulse_start();
    check("cap_err_clr", {31'b0, error}, 32'd0);
    send_word(32'h0000_0200);
    for (int i = 0; i < 512; i++) send_word(32'hA500_0000 | 32'(i));
    wait_end(20);
    check("cap_done",     {31'b0, done}, 32'd1);
    check("cap_wr_count", wr_count,  32'd512);
    check("cap_last",     last_addr, 32'd511);
    check("cap_mem0",     mem[0],    32'hA500_0000);
    check("cap_mem511",   mem[511],  32'hA500_01FF);

    // Zero count
    wr_count = 0;
    pulse_start();
    send_word(32'h0000_0000);
    wait_end(10);
    check("zero_done",     {31'b0, done},     32'd1);
    check("zero_hold",     {31'b0, cpu_hold}, 32'd0);
    check("zero_no_write", wr_count, 32'd0);

    // Abort mid-word: byte offered with abort is dropped
    wr_count = 0;
    pulse_start();
    send_word(32'h0000_0002);
    send_word(32'h1122_3344);
    send_byte(8'h55);
    send_byte(8'h66);
    byte_in    = 8'h77;
    byte_valid = 1'b1;
    abort      = 1'b1;
    tick();
    abort      = 1'b0;
    byte_valid = 1'b0;
    check("abort_error", {31'b0, error},    32'd1);
    check("abort_busy",  {31'b0, busy},     32'd0);
    check("abort_hold",  {31'b0, cpu_hold}, 32'd1);
    tick();
    tick();
    check("abort_wr_count", wr_count, 32'd1);
    check("abort_mem0",     mem[0],   32'h1122_3344);

    // Restart from ERR with start and abort together: start wins when idle
    wr_count = 0;
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("restart_busy", {31'b0, busy}, 32'd1);
    send_byte(8'h00);
    start = 1'b1;
    send_byte(8'h00);
    start = 1'b0;
    send_byte(8'h00);
    send_byte(8'h01);
    send_word(32'hDEAD_BEEF);
    wait_end(10);
    check("restart_done",     {31'b0, done}, 32'd1);
    check("restart_wr_count", wr_count, 32'd1);
    check("restart_mem0",     mem[0],   32'hDEAD_BEEF);

    // Reset mid-load
    pulse_start();
    send_word(32'h0000_0002);
    send_word(32'h0102_0304);
    send_byte(8'h05);
    rst_n = 1'b0;
    tick();
    check("mrst_wr_en",      {31'b0, wr_en},      32'd0);
    check("mrst_write_addr", {23'b0, write_addr}, 32'd0);
    check("mrst_data_in",    data_in,             32'd0);
    check("mrst_busy",       {31'b0, busy},       32'd0);
    check("mrst_done",       {31'b0, done},       32'd0);
    check("mrst_error",      {31'b0, error},      32'd0);
    check("mrst_hold",       {31'b0, cpu_hold},   32'd1);
    check("mrst_ready",      {31'b0, byte_ready}, 32'd0);
    rst_n = 1'b1;
    tick();
    wr_count  = 0;
    last_addr = -1;
    pulse_start();
    send_word(32'h0000_0001);
    send_word(32'hCAFE_BABE);
    wait_end(10);
    check("post_rst_done",     {31'b0, done}, 32'd1);
    check("post_rst_wr_count", wr_count,  32'd1);
    check("post_rst_addr",     last_addr, 32'd0);
    check("post_rst_mem0",     mem[0],    32'hCAFE_BABE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
